// File: rtl/lcd_ui_pkg.sv
// Shared types for the LCD touch UI controller: screen states, region actions
// and the hit-test table entry.
package lcd_ui_pkg;

   localparam int unsigned CW_MAX    = 15;
   localparam int unsigned PAGE_MENU = 0;
   localparam int unsigned PAGE_APP  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      MENU = 2'd2,
      APP  = 2'd3
   } ui_state_e;

   typedef enum logic [1:0] {
      ACT_NONE   = 2'd0,
      ACT_APP    = 2'd1,
      ACT_REINIT = 2'd2,
      ACT_MENU   = 2'd3
   } region_act_e;

   // Coordinates are held at the widest legal width and zero-extended.
   typedef struct packed {
      logic              en;
      logic [1:0]        page;
      region_act_e       act;
      logic [CW_MAX-1:0] x_lo;
      logic [CW_MAX-1:0] x_hi;
      logic [CW_MAX-1:0] y_lo;
      logic [CW_MAX-1:0] y_hi;
   } region_t;

endpackage

// File: rtl/lcd_touch_debounce.sv
// Release debouncer: accepts a release when idle, then locks out further
// releases for DEBOUNCE_CYC cycles.
module lcd_touch_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 10000000
) (
   input  logic pclk,
   input  logic rst_n,
   input  logic i_release,
   output logic o_accept_c
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_busy;

   assign w_busy     = (r_cnt != '0);
   assign o_accept_c = i_release && !w_busy;

   // Counter runs 1..DEBOUNCE_CYC while locked out; zero means idle.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (o_accept_c) begin
         r_cnt <= CNT_W'(1);
      end else if (w_busy) begin
         r_cnt <= (r_cnt == CNT_W'(DEBOUNCE_CYC)) ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lcd_touch_ui_ctrl.sv
// LCD UI state controller: debounced touch releases are hit-tested against a
// CPU-programmed region table, drive the screen FSM and are queued to the CPU.
module lcd_touch_ui_ctrl
   import lcd_ui_pkg::*;
#(
   parameter  int unsigned N_REGION     = 8,
   parameter  int unsigned COORD_W      = 10,
   parameter  int unsigned DEBOUNCE_CYC = 10000000,
   localparam int unsigned IDX_W        = (N_REGION > 1) ? $clog2(N_REGION) : 1,
   localparam int unsigned CFG_W        = 5 + 4 * COORD_W,
   localparam int unsigned EVT_W        = 2 * COORD_W + 5
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             init_finish,
   input  logic             touch_flag,
   input  logic             release_flag,
   input  logic [31:0]      coordinate,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [CFG_W-1:0] cfg_wdata,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [EVT_W-1:0] evt_data,
   output logic             evt_ovf,
   output logic [31:0]      touch_reg,
   output logic             init_main,
   output logic             enable,
   output logic             cpu_work,
   output logic             cpu_draw
);

   logic [COORD_W-1:0] w_cx, w_cy;
   logic [CW_MAX-1:0]  w_cx_ext, w_cy_ext;
   logic               w_accept, w_load, w_pop;
   logic [1:0]         w_page_sel;
   region_t            w_cfg_entry;
   region_t            r_table [N_REGION];
   logic [N_REGION-1:0] w_match;
   logic               w_hit;
   logic [3:0]         w_hit_idx;
   region_act_e        w_hit_act;

   ui_state_e          r_state, w_state_nxt;
   logic               r_enable, w_enable_nxt;
   logic               r_cpu_work, w_cpu_work_nxt;
   logic               r_cpu_draw, w_cpu_draw_nxt;
   logic               r_init_main, w_init_main_nxt;

   logic               r_evt_valid, r_evt_ovf;
   logic [EVT_W-1:0]   r_evt_data, w_evt_new;

   // Byte-swapped little-endian coordinates, truncated to COORD_W.
   assign w_cx     = COORD_W'({coordinate[23:16], coordinate[31:24]});
   assign w_cy     = COORD_W'({coordinate[7:0],   coordinate[15:8]});
   assign w_cx_ext = CW_MAX'(w_cx);
   assign w_cy_ext = CW_MAX'(w_cy);

   assign touch_reg = {touch_flag | release_flag, 31'({w_cx, w_cy})};

   lcd_touch_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .i_release  (release_flag),
      .o_accept_c (w_accept)
   );

   always_comb begin
      w_cfg_entry      = '0;
      w_cfg_entry.en   = cfg_wdata[CFG_W-1];
      w_cfg_entry.page = cfg_wdata[CFG_W-2 -: 2];
      w_cfg_entry.act  = region_act_e'(cfg_wdata[CFG_W-4 -: 2]);
      w_cfg_entry.x_lo = CW_MAX'(cfg_wdata[4*COORD_W-1 -: COORD_W]);
      w_cfg_entry.x_hi = CW_MAX'(cfg_wdata[3*COORD_W-1 -: COORD_W]);
      w_cfg_entry.y_lo = CW_MAX'(cfg_wdata[2*COORD_W-1 -: COORD_W]);
      w_cfg_entry.y_hi = CW_MAX'(cfg_wdata[COORD_W-1 -: COORD_W]);
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_REGION; i++) r_table[i] <= '0;
      end else if (cfg_we && (32'(cfg_idx) < N_REGION)) begin
         r_table[cfg_idx] <= w_cfg_entry;
      end
   end

   // Only MENU and APP have a page; other states never match.
   always_comb begin
      w_page_sel = 2'b00;
      if (r_state == MENU) w_page_sel = 2'(1 << PAGE_MENU);
      if (r_state == APP)  w_page_sel = 2'(1 << PAGE_APP);
   end

   for (genvar g = 0; g < N_REGION; g++) begin : g_match
      assign w_match[g] = r_table[g].en && (|(r_table[g].page & w_page_sel)) &&
                          (r_table[g].x_lo <= w_cx_ext) && (w_cx_ext <= r_table[g].x_hi) &&
                          (r_table[g].y_lo <= w_cy_ext) && (w_cy_ext <= r_table[g].y_hi);
   end

   // Scan high to low so the lowest matching index is the last one written.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = 4'd0;
      w_hit_act = ACT_NONE;
      for (int i = int'(N_REGION) - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_hit     = 1'b1;
            w_hit_idx = 4'(i);
            w_hit_act = r_table[i].act;
         end
      end
   end

   assign w_load    = w_accept && ((r_state == MENU) || (r_state == APP));
   assign w_pop     = r_evt_valid && evt_ready;
   assign w_evt_new = {w_hit, w_hit_idx, w_cx, w_cy};

   always_comb begin
      w_state_nxt     = r_state;
      w_enable_nxt    = r_enable;
      w_cpu_work_nxt  = r_cpu_work;
      w_cpu_draw_nxt  = r_cpu_draw;
      w_init_main_nxt = 1'b0;
      case (r_state)
         IDLE: w_state_nxt = INIT;
         INIT: begin
            if (init_finish) begin
               w_state_nxt    = MENU;
               w_enable_nxt   = 1'b1;
               w_cpu_work_nxt = 1'b1;
               w_cpu_draw_nxt = 1'b0;
            end
         end
         MENU, APP: begin
            if (w_accept && w_hit) begin
               case (w_hit_act)
                  ACT_APP: begin
                     w_state_nxt    = APP;
                     w_cpu_draw_nxt = 1'b1;
                  end
                  ACT_MENU: begin
                     w_state_nxt    = MENU;
                     w_cpu_draw_nxt = 1'b0;
                  end
                  ACT_REINIT: begin
                     w_state_nxt     = INIT;
                     w_init_main_nxt = 1'b1;
                     w_cpu_draw_nxt  = 1'b0;
                     w_cpu_work_nxt  = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_enable    <= 1'b0;
         r_cpu_work  <= 1'b0;
         r_cpu_draw  <= 1'b0;
         r_init_main <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_enable    <= w_enable_nxt;
         r_cpu_work  <= w_cpu_work_nxt;
         r_cpu_draw  <= w_cpu_draw_nxt;
         r_init_main <= w_init_main_nxt;
      end
   end

   // Single-entry event slot; a load wins over a same-cycle pop.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_evt_valid <= 1'b0;
         r_evt_data  <= '0;
         r_evt_ovf   <= 1'b0;
      end else begin
         if (w_load && (!r_evt_valid || w_pop)) begin
            r_evt_valid <= 1'b1;
            r_evt_data  <= w_evt_new;
         end else if (w_pop) begin
            r_evt_valid <= 1'b0;
         end
         if (w_load && r_evt_valid && !w_pop) r_evt_ovf <= 1'b1;
      end
   end

   assign evt_valid = r_evt_valid;
   assign evt_data  = r_evt_data;
   assign evt_ovf   = r_evt_ovf;
   assign init_main = r_init_main;
   assign enable    = r_enable;
   assign cpu_work  = r_cpu_work;
   assign cpu_draw  = r_cpu_draw;

endmodule

// File: tb/tb_lcd_touch_ui_ctrl.sv
// Directed bench for lcd_touch_ui_ctrl with an event scoreboard queue.
module tb_lcd_touch_ui_ctrl;

   localparam int unsigned N_REGION     = 4;
   localparam int unsigned COORD_W      = 10;
   localparam int unsigned DEBOUNCE_CYC = 16;
   localparam int unsigned IDX_W        = 2;
   localparam int unsigned CFG_W        = 5 + 4 * COORD_W;
   localparam int unsigned EVT_W        = 2 * COORD_W + 5;

   logic             pclk = 1'b0;
   logic             rst_n;
   logic             init_finish;
   logic             touch_flag;
   logic             release_flag;
   logic [31:0]      coordinate;
   logic             cfg_we;
   logic [IDX_W-1:0] cfg_idx;
   logic [CFG_W-1:0] cfg_wdata;
   logic             evt_valid;
   logic             evt_ready;
   logic [EVT_W-1:0] evt_data;
   logic             evt_ovf;
   logic [31:0]      touch_reg;
   logic             init_main;
   logic             enable;
   logic             cpu_work;
   logic             cpu_draw;

   logic [EVT_W-1:0] sb_q [$];
   int               n_assert = 0;
   int               n_fail   = 0;

   always #5 pclk = ~pclk;

   lcd_touch_ui_ctrl #(
      .N_REGION     (N_REGION),
      .COORD_W      (COORD_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) dut (
      .pclk         (pclk),
      .rst_n        (rst_n),
      .init_finish  (init_finish),
      .touch_flag   (touch_flag),
      .release_flag (release_flag),
      .coordinate   (coordinate),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_wdata    (cfg_wdata),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_data     (evt_data),
      .evt_ovf      (evt_ovf),
      .touch_reg    (touch_reg),
      .init_main    (init_main),
      .enable       (enable),
      .cpu_work     (cpu_work),
      .cpu_draw     (cpu_draw)
   );

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_coord(input logic [15:0] x, input logic [15:0] y);
      return {x[7:0], x[15:8], y[7:0], y[15:8]};
   endfunction

   function automatic logic [CFG_W-1:0] mk_cfg(input logic en, input logic [1:0] page,
                                               input logic [1:0] act, input int xlo,
                                               input int xhi, input int ylo, input int yhi);
      return {en, page, act, COORD_W'(xlo), COORD_W'(xhi), COORD_W'(ylo), COORD_W'(yhi)};
   endfunction

   function automatic logic [EVT_W-1:0] ev(input logic hit, input logic [3:0] idx,
                                           input int x, input int y);
      return {hit, idx, COORD_W'(x), COORD_W'(y)};
   endfunction

   task automatic cfg(input int idx, input logic [CFG_W-1:0] data);
      cfg_we    = 1'b1;
      cfg_idx   = IDX_W'(idx);
      cfg_wdata = data;
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic rel(input logic [15:0] x, input logic [15:0] y);
      coordinate   = mk_coord(x, y);
      release_flag = 1'b1;
      step();
      release_flag = 1'b0;
   endtask

   task automatic check_evt(input string tag);
      for (int k = 0; k < 8 && evt_valid !== 1'b1; k++) step();
      chk({tag, "_valid"}, 64'(evt_valid), 64'd1);
      n_assert++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_sb: observed queue size %0d expected nonzero", tag, sb_q.size());
      end
      if (sb_q.size() > 0) chk({tag, "_data"}, 64'(evt_data), 64'(sb_q.pop_front()));
   endtask

   task automatic pop_event(input string tag);
      check_evt(tag);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      chk({tag, "_popped"}, 64'(evt_valid), 64'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      init_finish  = 1'b0;
      touch_flag   = 1'b0;
      release_flag = 1'b0;
      coordinate   = '0;
      cfg_we       = 1'b0;
      cfg_idx      = '0;
      cfg_wdata    = '0;
      evt_ready    = 1'b0;
      idle(3);

      chk("rst_enable",    64'(enable),    64'd0);
      chk("rst_cpu_work",  64'(cpu_work),  64'd0);
      chk("rst_cpu_draw",  64'(cpu_draw),  64'd0);
      chk("rst_init_main", 64'(init_main), 64'd0);
      chk("rst_evt_valid", 64'(evt_valid), 64'd0);
      chk("rst_evt_ovf",   64'(evt_ovf),   64'd0);
      chk("rst_touch_reg", 64'(touch_reg), 64'd0);

      // Release while in INIT starts a lockout but yields no event
      rst_n = 1'b1;
      idle(2);
      rel(16'd100, 16'd200);
      step();
      chk("init_rel_no_evt", 64'(evt_valid), 64'd0);
      chk("init_enable",     64'(enable),    64'd0);
      idle(2);
      init_finish = 1'b1;
      step();
      init_finish = 1'b0;
      chk("menu_enable",   64'(enable),    64'd1);
      chk("menu_cpu_work", 64'(cpu_work),  64'd1);
      chk("menu_cpu_draw", 64'(cpu_draw),  64'd0);
      chk("menu_evt",      64'(evt_valid), 64'd0);
      idle(20);

      // Region 0 hit in MENU, with truncated high coordinate bits
      cfg(0, mk_cfg(1'b1, 2'b01, 2'd1, 60, 209, 70, 369));
      coordinate   = mk_coord(16'hFC64, 16'h80C8);
      touch_flag   = 1'b1;
      #1;
      chk("touch_reg", 64'(touch_reg), 64'(32'h8000_0000 | (32'd100 << 10) | 32'd200));
      touch_flag   = 1'b0;
      release_flag = 1'b1;
      sb_q.push_back(ev(1'b1, 4'd0, 100, 200));
      step();
      release_flag = 1'b0;
      chk("r0_cpu_draw", 64'(cpu_draw), 64'd1);
      idle(4);
      rel(16'd150, 16'd300);
      chk("lockout_ovf", 64'(evt_ovf), 64'd0);
      pop_event("r0_evt");
      idle(10);
      // Accepted at 17 cycles; region 0 is MENU-only so APP misses
      sb_q.push_back(ev(1'b0, 4'd0, 150, 300));
      rel(16'd150, 16'd300);
      chk("app_miss_draw", 64'(cpu_draw), 64'd1);
      pop_event("app_miss_evt");

      // Overlapping regions 1 (MENU act) and 2 (APP act)
      cfg(1, mk_cfg(1'b1, 2'b11, 2'd3, 300, 400, 300, 400));
      cfg(2, mk_cfg(1'b1, 2'b11, 2'd1, 350, 500, 350, 500));
      idle(20);
      sb_q.push_back(ev(1'b1, 4'd1, 370, 370));
      rel(16'd370, 16'd370);
      chk("ovl_cpu_draw", 64'(cpu_draw), 64'd0);
      pop_event("ovl_evt");
      idle(20);
      sb_q.push_back(ev(1'b0, 4'd0, 59, 200));
      rel(16'd59, 16'd200);
      chk("edge_miss_draw", 64'(cpu_draw), 64'd0);
      pop_event("edge_miss_evt");
      idle(20);
      sb_q.push_back(ev(1'b1, 4'd0, 60, 70));
      rel(16'd60, 16'd70);
      chk("edge_hit_draw", 64'(cpu_draw), 64'd1);
      pop_event("edge_hit_evt");
      idle(20);
      sb_q.push_back(ev(1'b1, 4'd2, 450, 450));
      rel(16'd450, 16'd450);
      chk("r2_cpu_draw", 64'(cpu_draw), 64'd1);
      pop_event("r2_evt");
      idle(20);

      // Region 3 written in the same cycle as the release: old entry used
      cfg_we    = 1'b1;
      cfg_idx   = 2'd3;
      cfg_wdata = mk_cfg(1'b1, 2'b10, 2'd2, 600, 700, 10, 50);
      sb_q.push_back(ev(1'b0, 4'd0, 650, 30));
      rel(16'd650, 16'd30);
      cfg_we = 1'b0;
      chk("cfg_race_draw", 64'(cpu_draw), 64'd1);
      chk("cfg_race_main", 64'(init_main), 64'd0);
      pop_event("cfg_race_evt");
      idle(20);
      sb_q.push_back(ev(1'b1, 4'd3, 650, 30));
      rel(16'd650, 16'd30);
      chk("reinit_main",     64'(init_main), 64'd1);
      chk("reinit_cpu_work", 64'(cpu_work),  64'd0);
      chk("reinit_cpu_draw", 64'(cpu_draw),  64'd0);
      step();
      chk("reinit_main_pulse", 64'(init_main), 64'd0);
      pop_event("reinit_evt");
      idle(20);
      rel(16'd100, 16'd200);
      step();
      chk("reinit_rel_no_evt", 64'(evt_valid), 64'd0);
      init_finish = 1'b1;
      step();
      init_finish = 1'b0;
      chk("remenu_cpu_work", 64'(cpu_work), 64'd1);
      idle(20);

      // Pop in the load cycle takes the new event without overflow
      sb_q.push_back(ev(1'b0, 4'd0, 900, 900));
      rel(16'd900, 16'd900);
      idle(20);
      check_evt("pl_first");
      evt_ready = 1'b1;
      sb_q.push_back(ev(1'b0, 4'd0, 800, 800));
      rel(16'd800, 16'd800);
      evt_ready = 1'b0;
      chk("pl_ovf", 64'(evt_ovf), 64'd0);
      pop_event("pl_second");
      idle(20);

      // Full slot with no pop drops the newer event
      sb_q.push_back(ev(1'b0, 4'd0, 901, 902));
      rel(16'd901, 16'd902);
      idle(20);
      rel(16'd903, 16'd904);
      chk("ovf_set", 64'(evt_ovf), 64'd1);
      pop_event("ovf_kept");
      chk("ovf_sticky", 64'(evt_ovf), 64'd1);
      idle(20);

      // Reset mid-lockout with an event pending clears everything
      rel(16'd100, 16'd200);
      rst_n = 1'b0;
      idle(2);
      chk("rst2_evt_valid", 64'(evt_valid), 64'd0);
      chk("rst2_evt_ovf",   64'(evt_ovf),   64'd0);
      chk("rst2_cpu_draw",  64'(cpu_draw),  64'd0);
      chk("rst2_enable",    64'(enable),    64'd0);
      rst_n = 1'b1;
      step();
      init_finish = 1'b1;
      step();
      init_finish = 1'b0;
      sb_q.push_back(ev(1'b0, 4'd0, 100, 200));
      rel(16'd100, 16'd200);
      chk("rst2_table_draw", 64'(cpu_draw), 64'd0);
      pop_event("rst2_evt");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
